// File: rtl/mem_lsu_pkg.sv
// Shared widths, size/state encodings and address-alignment helpers for the load/store unit.
package mem_lsu_pkg;

  localparam int API_ADDR_WIDTH = 32;
  localparam int API_DATA_WIDTH = 32;

  localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
  localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
  localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RDATA = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  // Size 2'b11 behaves as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      LSU_SIZE_BYTE: is_misaligned = 1'b0;
      LSU_SIZE_HALF: is_misaligned = lo[0];
      default:       is_misaligned = |lo;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      LSU_SIZE_BYTE: align_lo = lo;
      LSU_SIZE_HALF: align_lo = {lo[1], 1'b0};
      default:       align_lo = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: write mask, lane-replicated store data and extended load data.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wr_mask,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data
);

  logic [31:0] byte_shifted;
  logic [31:0] half_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign byte_shifted = rdata >> {addr_lo, 3'b000};
  assign half_shifted = rdata >> {addr_lo[1], 4'b0000};
  assign ld_byte      = byte_shifted[7:0];
  assign ld_half      = half_shifted[15:0];

  always_comb begin
    wr_mask   = 4'b0000;
    wdata_rep = wdata;
    ld_data   = rdata;
    case (size)
      LSU_SIZE_BYTE: begin
        wr_mask   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        ld_data   = uns ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      LSU_SIZE_HALF: begin
        wr_mask   = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        ld_data   = uns ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        wr_mask   = 4'b1111;
        wdata_rep = wdata;
        ld_data   = rdata;
      end
    endcase
    if (!we) wr_mask = 4'b0000;
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of the data RAM: one request at a time, 3-cycle loads, 2-cycle stores.
// LSU_MISALIGN_TRAP_EN: misaligned half/word requests return rsp_err_o without a RAM access.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = API_ADDR_WIDTH,
  parameter int DATA_WIDTH = API_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [3:0]            ram_wr_mask_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  lsu_state_e state, state_nxt;

  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  accept;
  logic                  trap_req;
  logic [1:0]            addr_lo_in;
  logic                  enter_resp;
  logic [3:0]            mask_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] ld_c;

  assign accept = req_valid_i && (state == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_req   = is_misaligned(req_size_i, req_addr_i[1:0]);
  assign addr_lo_in = req_addr_i[1:0];
`else
  // Misaligned requests are silently rounded down to their natural alignment.
  assign trap_req   = 1'b0;
  assign addr_lo_in = align_lo(req_size_i, req_addr_i[1:0]);
`endif

  mem_lsu_align u_align (
    .we        (we_q),
    .size      (size_q),
    .uns       (uns_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (ram_rdata_i),
    .wr_mask   (mask_c),
    .wdata_rep (wdata_c),
    .ld_data   (ld_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    ram_en_o      = 1'b0;
    ram_addr_o    = '0;
    ram_wdata_o   = '0;
    ram_wr_mask_o = 4'b0000;
    case (state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (accept) state_nxt = trap_req ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        ram_en_o      = 1'b1;
        ram_addr_o    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        ram_wdata_o   = wdata_c;
        ram_wr_mask_o = mask_c;
        state_nxt     = we_q ? ST_RESP : ST_RDATA;
      end
      ST_RDATA: state_nxt = ST_RESP;
      default: begin
        rsp_valid_o = 1'b1;
        state_nxt   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      size_q  <= LSU_SIZE_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we_i;
      size_q  <= req_size_i;
      uns_q   <= req_unsigned_i;
      addr_q  <= {req_addr_i[ADDR_WIDTH-1:2], addr_lo_in};
      wdata_q <= req_wdata_i;
    end
  end

  // Response registers update only on entry to RESP so they hold between responses.
  assign enter_resp = (state != ST_RESP) && (state_nxt == ST_RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        rdata_q <= '0;
    else if (enter_resp) rdata_q <= (state == ST_RDATA) ? ld_c : '0;
  end

  assign rsp_rdata_o = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        err_q <= 1'b0;
    else if (enter_resp) err_q <= (state == ST_IDLE);
  end

  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu with a behavioural RAM; directed vectors cover both trap configurations.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        ram_en_o;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic [3:0]  ram_wr_mask_o;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .ram_en_o       (ram_en_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_wr_mask_o  (ram_wr_mask_o),
    .ram_rdata_i    (ram_rdata_i)
  );

  // Behavioural RAM: registered read, byte-lane writes.
  logic [31:0] mem [0:255];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      ram_rdata_i <= 32'h0;
    end else if (ram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_wr_mask_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      ram_rdata_i <= mem[ram_addr_o[9:2]];
    end
  end

  typedef struct { logic [31:0] rdata; logic err; int lat; } rsp_t;
  typedef struct { logic [31:0] addr; logic [3:0] mask; logic [31:0] wdata; logic we; } ram_t;

  rsp_t rsp_q[$];
  ram_t ram_q[$];
  int   acc_q[$];
  int   total = 0, bad = 0;
  int   cyc = 0, ram_cnt = 0, exp_ram_cnt = 0;
  rsp_t mon_s;
  ram_t mon_r;
  int   mon_a;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: observe accepts, RAM pulses and responses; compare against queued expectations.
  always @(negedge clk) begin
    if (reset_n) begin
      if (req_valid_i && req_ready_o) acc_q.push_back(cyc);
      if (ram_en_o) begin
        ram_cnt <= ram_cnt + 1;
        chk("ready_low_in_issue", {31'b0, req_ready_o}, 32'd0);
        if (ram_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ram_unexpected: got access addr %h required no access", ram_addr_o);
        end else begin
          mon_r = ram_q.pop_front();
          chk("ram_addr", ram_addr_o, mon_r.addr);
          chk("ram_mask", {28'b0, ram_wr_mask_o}, {28'b0, mon_r.mask});
          if (mon_r.we) chk("ram_wdata", ram_wdata_o, mon_r.wdata);
        end
      end
      if (rsp_valid_o) begin
        chk("ready_low_in_resp", {31'b0, req_ready_o}, 32'd0);
        if (rsp_q.size() == 0 || acc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got response %h required none", rsp_rdata_o);
        end else begin
          mon_s = rsp_q.pop_front();
          mon_a = acc_q.pop_front();
          chk("rsp_rdata", rsp_rdata_o, mon_s.rdata);
          chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, mon_s.err});
          chk("rsp_latency", cyc - mon_a, mon_s.lat);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                      input logic ram_acc, input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                      input logic [31:0] exp_wdata, input logic hold);
    int n;
    rsp_q.push_back('{exp_rd, exp_err, exp_lat});
    if (ram_acc) begin
      ram_q.push_back('{exp_addr, exp_mask, exp_wdata, we});
      exp_ram_cnt++;
    end
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_valid_i    = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready_o) break;
      n++;
      if (n > 20) begin
        total++; bad++;
        $display("FAIL accept_timeout: got ready low for %0d cycles required accept", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid_i = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; mem_clr = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
    #2;
    chk("rst_ready",  {31'b0, req_ready_o}, 32'd1);
    chk("rst_rsp_vld", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_rdata",  rsp_rdata_o, 32'd0);
    chk("rst_err",    {31'b0, rsp_err_o}, 32'd0);
    chk("rst_ram_en", {31'b0, ram_en_o}, 32'd0);
    chk("rst_mask",   {28'b0, ram_wr_mask_o}, 32'd0);
    chk("rst_addr",   ram_addr_o, 32'd0);
    chk("rst_wdata",  ram_wdata_o, 32'd0);
    @(posedge clk); @(posedge clk);
    mem_clr = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // we size uns addr wdata | rsp lat | ram? addr mask wdata | hold
    send(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0);
    send(0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 3, 1, 32'h100, 4'b0000, 32'h0, 0);
    send(1, 2'b00, 0, 32'h203, 32'hABCDEF80, 32'h0,        0, 2, 1, 32'h200, 4'b1000, 32'h80808080, 0);
    send(0, 2'b00, 0, 32'h203, 32'h0,        32'hFFFFFF80, 0, 3, 1, 32'h200, 4'b0000, 32'h0, 0);
    send(0, 2'b00, 1, 32'h203, 32'h0,        32'h00000080, 0, 3, 1, 32'h200, 4'b0000, 32'h0, 0);
    send(1, 2'b01, 0, 32'h302, 32'h55558001, 32'h0,        0, 2, 1, 32'h300, 4'b1100, 32'h80018001, 0);
    send(0, 2'b01, 0, 32'h302, 32'h0,        32'hFFFF8001, 0, 3, 1, 32'h300, 4'b0000, 32'h0, 0);
    send(0, 2'b01, 1, 32'h302, 32'h0,        32'h00008001, 0, 3, 1, 32'h300, 4'b0000, 32'h0, 0);
    send(0, 2'b10, 0, 32'h300, 32'h0,        32'h80010000, 0, 3, 1, 32'h300, 4'b0000, 32'h0, 0);
    send(1, 2'b00, 0, 32'h201, 32'h0000007F, 32'h0,        0, 2, 1, 32'h200, 4'b0010, 32'h7F7F7F7F, 0);
    send(0, 2'b00, 0, 32'h201, 32'h0,        32'h0000007F, 0, 3, 1, 32'h200, 4'b0000, 32'h0, 0);
    send(0, 2'b11, 0, 32'h200, 32'h0,        32'h80007F00, 0, 3, 1, 32'h200, 4'b0000, 32'h0, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    send(0, 2'b10, 0, 32'h101, 32'h0,        32'h0,        1, 1, 0, 32'h0,   4'b0000, 32'h0, 0);
    send(1, 2'b01, 0, 32'h303, 32'h00001234, 32'h0,        1, 1, 0, 32'h0,   4'b0000, 32'h0, 0);
    send(0, 2'b10, 0, 32'h300, 32'h0,        32'h80010000, 0, 3, 1, 32'h300, 4'b0000, 32'h0, 0);
`else
    send(0, 2'b10, 0, 32'h101, 32'h0,        32'hDEADBEEF, 0, 3, 1, 32'h100, 4'b0000, 32'h0, 0);
    send(1, 2'b01, 0, 32'h303, 32'h00001234, 32'h0,        0, 2, 1, 32'h300, 4'b1100, 32'h12341234, 0);
    send(0, 2'b10, 0, 32'h300, 32'h0,        32'h12340000, 0, 3, 1, 32'h300, 4'b0000, 32'h0, 0);
`endif

    // Back-to-back loads with req_valid_i held high throughout.
    send(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 3, 1, 32'h100, 4'b0000, 32'h0, 1);
    send(0, 2'b00, 1, 32'h201, 32'h0, 32'h0000007F, 0, 3, 1, 32'h200, 4'b0000, 32'h0, 1);
    send(0, 2'b10, 0, 32'h200, 32'h0, 32'h80007F00, 0, 3, 1, 32'h200, 4'b0000, 32'h0, 0);

    // Reset while the load sits in RDATA: its response must never appear.
    send(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 3, 1, 32'h100, 4'b0000, 32'h0, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready",  {31'b0, req_ready_o}, 32'd1);
    chk("midrst_rsp_vld", {31'b0, rsp_valid_o}, 32'd0);
    chk("midrst_ram_en", {31'b0, ram_en_o}, 32'd0);
    chk("midrst_mask",   {28'b0, ram_wr_mask_o}, 32'd0);
    chk("midrst_addr",   ram_addr_o, 32'd0);
    chk("midrst_wdata",  ram_wdata_o, 32'd0);
    chk("midrst_rdata",  rsp_rdata_o, 32'd0);
    if (rsp_q.size() > 0) void'(rsp_q.pop_back());
    if (acc_q.size() > 0) void'(acc_q.pop_back());
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    send(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 3, 1, 32'h100, 4'b0000, 32'h0, 0);

    n = 0;
    while ((rsp_q.size() != 0 || ram_q.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("ram_queue_drained", ram_q.size(), 32'd0);
    chk("ram_pulse_count",   ram_cnt, exp_ram_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
